oplayback: RTL

- Playback stage directly downstream of the sequence generator.
- After the generator has filled the 32-entry sequence RAM with 4-bit values, this block reads the first `length` entries back in order.
- Each entry is shown on the LED output for a fixed hold time, followed by a blank gap.
- Signals completion to the game controller with a one-cycle `done` pulse.

---
 rtl/orion_pkg.sv | 38 +++
 rtl/oplay_timer.sv | 51 +++++
 rtl/oplayback.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/orion_pkg.sv
// ---------------------------------------------------------------------------
// orion_pkg -- constants and helpers shared by the sequence generator, the
// sequence RAM wrapper and the playback stage (oplayback).
//
// Contents:
//   SEQ_ADDR_W / SEQ_DATA_W / SEQ_DEPTH : sequence RAM geometry
//   state_t and ST_* constants          : playback FSM encoding
//   onehot_2to4()                       : 2-bit value to 4-bit one-hot decode
// ---------------------------------------------------------------------------
package orion_pkg;

  localparam int SEQ_ADDR_W = 5;
  localparam int SEQ_DATA_W = 4;
  localparam int SEQ_DEPTH  = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LATCH = 3'd2;
  localparam state_t ST_SHOW  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Decode a 2-bit value to a 4-bit one-hot pattern (never all-zero).
  function automatic logic [3:0] onehot_2to4(input logic [1:0] sel);
    logic [3:0] res;
    case (sel)
      2'd0:    res = 4'b0001;
      2'd1:    res = 4'b0010;
      2'd2:    res = 4'b0100;
      2'd3:    res = 4'b1000;
      default: res = 4'b0001;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/oplay_timer.sv
// ---------------------------------------------------------------------------
// oplay_timer -- up-counter used for both the SHOW and GAP phases of
// oplayback. The caller supplies the last count value of the current phase;
// `terminal` flags the final cycle of that phase.
//
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   clear     : force the count to 0 (wins over en)
//   en        : advance the count by one
//   last      : final count value of the running phase (phase length - 1)
//   terminal  : en is high and the count has reached `last`
// ---------------------------------------------------------------------------
module oplay_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic             terminal
);
  import orion_pkg::*;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next-count selection: clear has priority over counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = en && (count_q == last);

endmodule

// File: rtl/oplayback.sv
// ---------------------------------------------------------------------------
// oplayback -- plays back the first `length` entries of the sequence RAM on
// the LED output. Each entry is shown for HOLD_CYCLES clocks followed by a
// GAP_CYCLES blank; a one-cycle `done` pulse marks completion.
//
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   start     : level request to begin playback (honoured only when idle)
//   length    : entries to play, 0..32 (larger values clamp to 32)
//   rd_addr   : sequence RAM read address
//   rd_data   : RAM read data, valid one clock after rd_addr
//   led       : displayed value, 0 when blank
//   busy      : high whenever not idle
//   done      : single-cycle completion pulse
//
// Build option: define OPLAYBACK_ONEHOT_EN to show rd_data[1:0] as a one-hot
// pattern instead of the raw nibble. Timing is identical in both builds.
// ---------------------------------------------------------------------------
module oplayback #(
  parameter int ADDR_W      = orion_pkg::SEQ_ADDR_W,
  parameter int DATA_W      = orion_pkg::SEQ_DATA_W,
  parameter int HOLD_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int CNT_W       = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              done
);
  import orion_pkg::*;

  // Full RAM depth expressed in the width of `length`.
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] idx_q,     idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   len_q,     len_d;
  logic [DATA_W-1:0] led_q,     led_d;
  logic              done_q,    done_d;

  logic              tmr_clear_s;
  logic              tmr_en_s;
  logic              tmr_term_s;
  logic [CNT_W-1:0]  tmr_last_s;
  logic [DATA_W-1:0] disp_s;

  // The same timer serves SHOW and GAP; only its limit changes.
  assign tmr_last_s = (state_q == ST_GAP) ? CNT_W'(GAP_CYCLES - 1)
                                          : CNT_W'(HOLD_CYCLES - 1);

`ifdef OPLAYBACK_ONEHOT_EN
  assign disp_s = DATA_W'(onehot_2to4(rd_data[1:0]));
`else
  assign disp_s = rd_data;
`endif

  oplay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear_s),
    .en       (tmr_en_s),
    .last     (tmr_last_s),
    .terminal (tmr_term_s)
  );

  // Playback FSM next-state and output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    len_d       = len_q;
    led_d       = led_q;
    done_d      = 1'b0;
    tmr_clear_s = 1'b0;
    tmr_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            // Nothing to play: report completion immediately.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            len_d     = (length > LEN_MAX) ? LEN_MAX : length;
            idx_d     = '0;
            rd_addr_d = '0;
            state_d   = ST_FETCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // rd_addr is stable here; the RAM answers during LATCH.
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        led_d       = disp_s;
        tmr_clear_s = 1'b1;
        state_d     = ST_SHOW;
      end
      ST_SHOW: begin
        tmr_en_s = 1'b1;
        if (tmr_term_s) begin
          led_d       = '0;
          tmr_clear_s = 1'b1;
          state_d     = ST_GAP;
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_GAP: begin
        tmr_en_s = 1'b1;
        if (tmr_term_s) begin
          tmr_clear_s = 1'b1;
          if ({1'b0, idx_q} == (len_q - LEN_ONE)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            rd_addr_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d   = ST_FETCH;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_DONE: begin
        rd_addr_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        rd_addr_d = '0;
        led_d     = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rd_addr_q <= '0;
      len_q     <= '0;
      led_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      len_q     <= len_d;
      led_q     <= led_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign led     = led_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
